// File: rtl/sum_1_bit_core.sv
// ============================================================================
//  Module   : sum_1_bit_core
//  Summary  : Single-bit full adder with a registered result, a saturating
//             carry-event counter and an optional self-check enabled by the
//             SUM_1_BIT_SELF_CHECK_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_1_bit_core #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             Cin,
    input  logic             en,
    output logic             S,
    output logic             Cout,
    output logic             G,
    output logic             P,
    output logic             S_q,
    output logic             Cout_q,
    output logic             vld_q,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             chk_err
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic w_g;
    logic w_p;
    logic w_s;
    logic w_cout;

    assign w_g    = A & B;
    assign w_p    = A ^ B;
    assign w_s    = w_p ^ Cin;
    assign w_cout = w_g | (Cin & w_p);

    assign S    = w_s;
    assign Cout = w_cout;
    assign G    = w_g;
    assign P    = w_p;

    logic             r_s_q;
    logic             r_cout_q;
    logic             r_vld_q;
    logic [CNT_W-1:0] r_carry_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_q       <= 1'b0;
            r_cout_q    <= 1'b0;
            r_vld_q     <= 1'b0;
            r_carry_cnt <= '0;
        end else begin
            r_vld_q <= en;
            if (en) begin
                r_s_q    <= w_s;
                r_cout_q <= w_cout;
                // Counter sticks at all-ones rather than wrapping.
                if (w_cout && (r_carry_cnt != c_cnt_max)) begin
                    r_carry_cnt <= r_carry_cnt + 1'b1;
                end
            end
        end
    end

    assign S_q       = r_s_q;
    assign Cout_q    = r_cout_q;
    assign vld_q     = r_vld_q;
    assign carry_cnt = r_carry_cnt;

`ifdef SUM_1_BIT_SELF_CHECK_EN
    // Reference is an arithmetic add, deliberately not reusing the XOR/AND terms.
    logic [1:0] w_ref_sum;
    logic       r_chk_err;

    assign w_ref_sum = {1'b0, A} + {1'b0, B} + {1'b0, Cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_err <= 1'b0;
        end else if (en && (w_ref_sum != {w_cout, w_s})) begin
            r_chk_err <= 1'b1;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sum_1_bit_core.sv
// ============================================================================
//  Module   : tb_sum_1_bit_core
//  Summary  : Directed self-checking bench for sum_1_bit_core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_1_bit_core;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic        A;
    logic        B;
    logic        Cin;
    logic        en;
    logic        en2;

    logic        S, Cout, G, P, S_q, Cout_q, vld_q, chk_err;
    logic [15:0] carry_cnt;

    logic        S2, Cout2, G2, P2, S_q2, Cout_q2, vld_q2, chk_err2;
    logic [1:0]  carry_cnt2;

    int tests;
    int fails;

    sum_1_bit_core #(.CNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .en        (en),
        .S         (S),
        .Cout      (Cout),
        .G         (G),
        .P         (P),
        .S_q       (S_q),
        .Cout_q    (Cout_q),
        .vld_q     (vld_q),
        .carry_cnt (carry_cnt),
        .chk_err   (chk_err)
    );

    sum_1_bit_core #(.CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .rst       (rst2),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .en        (en2),
        .S         (S2),
        .Cout      (Cout2),
        .G         (G2),
        .P         (P2),
        .S_q       (S_q2),
        .Cout_q    (Cout_q2),
        .vld_q     (vld_q2),
        .carry_cnt (carry_cnt2),
        .chk_err   (chk_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_sum [8];
        logic [7:0] exp_g;
        logic [7:0] exp_p;
        logic [7:0] exp_cout;
        logic [2:0] v;
        logic [2:0] cnt_sat;

        exp_sum  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        exp_g    = 8'b1100_0000;   // bit i = G for vector i
        exp_p    = 8'b0011_1100;
        exp_cout = 8'b1110_1000;

        tests = 0;
        fails = 0;
        rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0;
        A = 1'b0; B = 1'b0; Cin = 1'b0;

        // Exhaustive combinational sweep
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {A, B, Cin} = v;
            #1;
            check($sformatf("comb_sum_%0d", i), {30'd0, Cout, S}, {30'd0, exp_sum[i]});
            check($sformatf("comb_g_%0d", i), {31'd0, G}, {31'd0, exp_g[i]});
            check($sformatf("comb_p_%0d", i), {31'd0, P}, {31'd0, exp_p[i]});
        end

        // Unknown input propagates as X
        A = 1'bx; B = 1'b0; Cin = 1'b0;
        #1;
        check("comb_x_s", {31'd0, S}, {31'd0, 1'bx});
        A = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_s_q", {31'd0, S_q}, 32'd0);
        check("rst_cout_q", {31'd0, Cout_q}, 32'd0);
        check("rst_vld_q", {31'd0, vld_q}, 32'd0);
        check("rst_cnt", {16'd0, carry_cnt}, 32'd0);
        check("rst_chk_err", {31'd0, chk_err}, 32'd0);

        // Registered capture of 1+1+0
        rst = 1'b0;
        A = 1'b1; B = 1'b1; Cin = 1'b0; en = 1'b1;
        tick();
        check("cap_s_q", {31'd0, S_q}, 32'd0);
        check("cap_cout_q", {31'd0, Cout_q}, 32'd1);
        check("cap_vld_q", {31'd0, vld_q}, 32'd1);
        check("cap_cnt", {16'd0, carry_cnt}, 32'd1);
        en = 1'b0;
        A = 1'b0; B = 1'b0;
        tick();
        check("hold_vld_q", {31'd0, vld_q}, 32'd0);
        check("hold_s_q", {31'd0, S_q}, 32'd0);
        check("hold_cout_q", {31'd0, Cout_q}, 32'd1);
        check("hold_cnt", {16'd0, carry_cnt}, 32'd1);

        // Capture without carry leaves counter unchanged
        A = 1'b1; B = 1'b0; Cin = 1'b0; en = 1'b1;
        tick();
        check("nocarry_s_q", {31'd0, S_q}, 32'd1);
        check("nocarry_cout_q", {31'd0, Cout_q}, 32'd0);
        check("nocarry_cnt", {16'd0, carry_cnt}, 32'd1);
        en = 1'b0;
        tick();

        // Saturation on the 2-bit counter instance
        rst2 = 1'b0;
        A = 1'b1; B = 1'b1; Cin = 1'b1; en2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            cnt_sat = (k > 3) ? 3'd3 : k[2:0];
            check($sformatf("sat_cnt_%0d", k), {30'd0, carry_cnt2}, {29'd0, cnt_sat});
        end
        en2 = 1'b0;
        check("sat_main_cnt_idle", {16'd0, carry_cnt}, 32'd1);

        // Reset in the middle of a back-to-back stream
        en = 1'b1;
        tick();
        tick();
        tick();
        check("stream_cnt", {16'd0, carry_cnt}, 32'd4);
        check("stream_s_q", {31'd0, S_q}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_s_q", {31'd0, S_q}, 32'd0);
        check("mid_rst_cout_q", {31'd0, Cout_q}, 32'd0);
        check("mid_rst_vld_q", {31'd0, vld_q}, 32'd0);
        check("mid_rst_cnt", {16'd0, carry_cnt}, 32'd0);
        rst = 1'b0;
        A = 1'b1; B = 1'b0; Cin = 1'b1;
        tick();
        check("post_rst_cout_q", {31'd0, Cout_q}, 32'd1);
        check("post_rst_s_q", {31'd0, S_q}, 32'd0);
        check("post_rst_cnt", {16'd0, carry_cnt}, 32'd1);
        check("post_rst_vld_q", {31'd0, vld_q}, 32'd1);

        // Reset dominates en; combinational path still live
        rst = 1'b1;
        A = 1'b1; B = 1'b1; Cin = 1'b1;
        #1;
        check("prio_comb", {30'd0, Cout, S}, 32'd3);
        tick();
        check("prio_s_q", {31'd0, S_q}, 32'd0);
        check("prio_cout_q", {31'd0, Cout_q}, 32'd0);
        check("prio_vld_q", {31'd0, vld_q}, 32'd0);
        check("prio_cnt", {16'd0, carry_cnt}, 32'd0);

        // Sweep with en=1: self-check flag must stay clear
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {A, B, Cin} = v;
            tick();
            check($sformatf("sweep_q_%0d", i), {30'd0, Cout_q, S_q}, {30'd0, exp_sum[i]});
            check($sformatf("sweep_chk_%0d", i), {31'd0, chk_err}, 32'd0);
        end
        check("sweep_cnt", {16'd0, carry_cnt}, 32'd4);
        check("sweep_cout_ref", {31'd0, Cout_q}, {31'd0, exp_cout[7]});
        en = 1'b0;
        tick();
        check("sweep_vld_drop", {31'd0, vld_q}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
